// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the bit-time
// divisor macro. Used by both the buffered TX and the UART RX path.
`ifndef UART_TX_BUFFERED_PKG_MACROS
`define UART_TX_BUFFERED_PKG_MACROS
`define UART_DIV(fclk, bauds) (((fclk) + (bauds) / 2) / (bauds))
`endif

package uart_tx_buffered_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock synchronous FIFO with show-ahead read data and an occupancy
// counter. A write while FULL is dropped even if a read frees a slot that edge.
module uart_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             CLK,
  input  logic             RST_,
  input  logic             WR,
  input  logic [Width-1:0] WDATA,
  input  logic             RD,
  output logic [Width-1:0] RDATA,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_depth_chk
    $error("uart_fifo: Depth must be a power of two and >= 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign FULL  = (count_q == CW'(Depth));
  assign EMPTY = (count_q == '0);
  assign RDATA = mem_q[rptr_q];

  assign wr_en = WR & ~FULL;
  assign rd_en = RD & ~EMPTY;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (rd_en) rptr_d = rptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wptr_q] <= WDATA;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser, frames sent back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
`ifndef FCLK
`define FCLK 12_000_000
`endif

module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned Bauds = 300,
  parameter int unsigned Fclk  = `FCLK,
  parameter int unsigned Depth = 4
) (
  input  logic       CLK,
  input  logic       RST_,
  input  logic [7:0] DIN,
  input  logic       OE,
  output logic       RDY,
  output logic       BUSY,
  output logic       TXD
);

  localparam int unsigned Div = `UART_DIV(Fclk, Bauds);
  localparam int unsigned CW  = $clog2(Div);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] DivLast = CW'(Div - 1);
  localparam logic [BW-1:0] BitLast = BW'(DATA_BITS - 1);

  if (Div < 2) begin : g_div_chk
    $error("uart_tx_buffered: bit time below 2 clock cycles");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 pop, bit_end;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_fifo #(
    .Width (DATA_BITS),
    .Depth (Depth)
  ) u_fifo (
    .CLK   (CLK),
    .RST_  (RST_),
    .WR    (OE),
    .WDATA (DIN),
    .RD    (pop),
    .RDATA (fifo_rdata),
    .FULL  (fifo_full),
    .EMPTY (fifo_empty)
  );

  assign RDY     = ~fifo_full;
  assign BUSY    = (state_q != S_IDLE) | ~fifo_empty;
  assign TXD     = txd_q;
  assign bit_end = (cnt_q == DivLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_rdata;
`endif
    end

    // TXD is registered from the next state so it switches on the same edge as the FSM.
    case (state_d)
      S_START: txd_d = START_LEVEL;
      S_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      S_STOP:  txd_d = STOP_LEVEL;
      default: txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed and random bench for uart_tx_buffered at Div=4, Depth=4.
module tb_uart_tx_buffered;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FC = FB * DIV;

  logic       CLK = 1'b0;
  logic       RST_ = 1'b0;
  logic       OE = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       RDY, BUSY, TXD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_buffered #(
    .Bauds (3_000_000),
    .Fclk  (12_000_000),
    .Depth (4)
  ) dut (
    .CLK  (CLK),
    .RST_ (RST_),
    .DIN  (DIN),
    .OE   (OE),
    .RDY  (RDY),
    .BUSY (BUSY),
    .TXD  (TXD)
  );

  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, 1'b1, b, 1'b0};
`endif
  endfunction

  // Bench RX: waits for a start bit, then samples each bit in its middle.
  task automatic rx_frame(input int budget, output logic [7:0] b, output logic par,
                          output logic framing_ok, output int start_cyc, output logic timeout);
    b = '0; par = 1'b0; framing_ok = 1'b0; start_cyc = 0; timeout = 1'b1;
    for (int w = 0; w < budget; w++) begin
      step(1);
      if (TXD === 1'b0) begin
        timeout = 1'b0;
        break;
      end
    end
    if (!timeout) begin
      start_cyc = cyc;
      step(DIV / 2);
      framing_ok = (TXD === 1'b0);
      for (int k = 0; k < 8; k++) begin
        step(DIV);
        b[k] = TXD;
      end
`ifdef UART_TX_PARITY_EN
      step(DIV);
      par = TXD;
`endif
      step(DIV);
      framing_ok = framing_ok & (TXD === 1'b1);
    end
  endtask

  task automatic test_reset();
    logic bad;
    RST_ = 1'b0; OE = 1'b0;
    step(3);
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", TXD); end
    checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", RDY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    RST_ = 1'b1;
    step(2);
    OE = 1'b1; DIN = 8'h00; step(1);
    DIN = 8'hFF; step(1);
    DIN = 8'h5A; step(1);
    OE = 1'b0;
    step(8);
    checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL midframe_low got=%b exp=0", TXD); end
    #3 RST_ = 1'b0;
    #1;
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL async_reset_txd got=%b exp=1", TXD); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", BUSY); end
    checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL async_reset_rdy got=%b exp=1", RDY); end
    step(2);
    RST_ = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 2 * FC; i++) begin
      step(1);
      if (TXD !== 1'b1 || BUSY !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL reset_discard got=line_active exp=idle"); end
  endtask

  task automatic test_single();
    logic [10:0] exp;
    exp = make_frame(8'h55);
    OE = 1'b1; DIN = 8'h55;
    step(1);
    OE = 1'b0;
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL single_latency got=%b exp=1", TXD); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy_queued got=%b exp=1", BUSY); end
    for (int i = 0; i < FC; i++) begin
      step(1);
      checks++;
      if (TXD !== exp[i / DIV]) begin
        errors++; $display("FAIL single_bit cycle=%0d got=%b exp=%b", i, TXD, exp[i / DIV]);
      end
    end
    step(1);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", BUSY); end
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL single_txd_end got=%b exp=1", TXD); end
  endtask

  task automatic test_burst();
    int starts[5];
    logic [7:0] b;
    logic par, fok, to;
    int sc;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          OE = 1'b1; DIN = 8'(i);
          checks++;
          if (RDY !== (i <= 5)) begin
            errors++; $display("FAIL burst_rdy write=%0d got=%b exp=%b", i, RDY, (i <= 5));
          end
          step(1);
        end
        OE = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          starts[k] = 0;
          rx_frame(60, b, par, fok, sc, to);
          starts[k] = sc;
          checks++;
          if (to || !fok || b !== 8'(k + 1)) begin
            errors++; $display("FAIL burst_frame idx=%0d got=%h fok=%b to=%b exp=%h", k, b, fok, to, 8'(k + 1));
          end
          if (to) break;
        end
      end
    join
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (starts[k] - starts[k - 1] != FC) begin
        errors++; $display("FAIL burst_gap idx=%0d got=%0d exp=%0d", k, starts[k] - starts[k - 1], FC);
      end
    end
    rx_frame(3 * FC, b, par, fok, sc, to);
    checks++; if (!to) begin errors++; $display("FAIL burst_dropped got=frame %h exp=none", b); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL burst_busy_end got=%b exp=0", BUSY); end
  endtask

  task automatic test_full_drop();
    logic [7:0] expb[6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    logic [7:0] b;
    logic par, fok, to;
    int sc;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          OE = 1'b1; DIN = 8'h11 + 8'(i);
          step(1);
        end
        OE = 1'b0;
        step(FC - 4);
        OE = 1'b1; DIN = 8'hEE;
        checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL full_rdy_before got=%b exp=0", RDY); end
        step(1);
        OE = 1'b0;
        checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL full_rdy_after_pop got=%b exp=1", RDY); end
        OE = 1'b1; DIN = 8'h16;
        step(1);
        OE = 1'b0;
        checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL full_rdy_refill got=%b exp=0", RDY); end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          rx_frame(60, b, par, fok, sc, to);
          checks++;
          if (to || !fok || b !== expb[k]) begin
            errors++; $display("FAIL full_frame idx=%0d got=%h fok=%b to=%b exp=%h", k, b, fok, to, expb[k]);
          end
          if (to) break;
        end
      end
    join
    rx_frame(3 * FC, b, par, fok, sc, to);
    checks++; if (!to) begin errors++; $display("FAIL full_extra_frame got=%h exp=none", b); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] vec[2] = '{8'h07, 8'h03};
    logic       expp[2] = '{1'b1, 1'b0};
    logic [7:0] b;
    logic par, fok, to;
    int sc, acc, w;
    for (int t = 0; t < 2; t++) begin
      OE = 1'b1; DIN = vec[t];
      step(1);
      OE = 1'b0;
      acc = cyc;
      rx_frame(10, b, par, fok, sc, to);
      checks++;
      if (to || !fok || b !== vec[t]) begin
        errors++; $display("FAIL parity_byte idx=%0d got=%h exp=%h", t, b, vec[t]);
      end
      checks++;
      if (par !== expp[t]) begin
        errors++; $display("FAIL parity_bit idx=%0d got=%b exp=%b", t, par, expp[t]);
      end
      w = 0;
      while (BUSY !== 1'b0 && w < 20) begin step(1); w++; end
      checks++;
      if (cyc - acc != 45) begin
        errors++; $display("FAIL parity_len idx=%0d got=%0d exp=45", t, cyc - acc);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] expq[$];
    logic [7:0] b, e;
    logic par, fok, to;
    int sc, gap, w;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 50));
          if (gap > 0) step(gap);
          w = 0;
          while (RDY !== 1'b1 && w < 2000) begin step(1); w++; end
          if (RDY !== 1'b1) begin
            checks++; errors++; $display("FAIL random_rdy_stuck got=%b exp=1", RDY);
            break;
          end
          DIN = 8'($urandom);
          OE = 1'b1;
          expq.push_back(DIN);
          step(1);
          OE = 1'b0;
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          rx_frame(3000, b, par, fok, sc, to);
          checks++;
          if (to) begin
            errors++; $display("FAIL random_timeout idx=%0d got=none exp=frame", n);
            break;
          end
          if (expq.size() == 0) begin
            errors++; $display("FAIL random_unexpected idx=%0d got=%h exp=none", n, b);
          end else begin
            e = expq.pop_front();
            if (b !== e || !fok) begin
              errors++; $display("FAIL random_byte idx=%0d got=%h fok=%b exp=%h", n, b, fok, e);
            end
          end
        end
      end
    join
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL random_leftover got=%0d exp=0", expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_drop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
